// File: rtl/cmac_pkg.sv
// Shared definitions for the complex MAC: FSM states, product indices, accumulator width.
package cmac_pkg;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

  localparam logic [1:0] K_RR = 2'd0;
  localparam logic [1:0] K_II = 2'd1;
  localparam logic [1:0] K_RI = 2'd2;
  localparam logic [1:0] K_IR = 2'd3;

  function automatic int acc_w(input int w, input int guard);
    return 2 * w + 1 + guard;
  endfunction

endpackage

// File: rtl/seq_mult_signed.sv
// W x W two's-complement shift-add multiplier; load pulse in, one-cycle valid pulse
// when the 2W-bit product is ready (bit 0 is folded into the load cycle).
module seq_mult_signed #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           valid,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      valid  <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      mcand  <= {{(W-1){a[W-1]}}, a, 1'b0};
      mplier <= b >> 1;
      prod   <= b[0] ? {{W{a[W-1]}}, a} : '0;
      cnt    <= CW'(W - 1);
      valid  <= 1'b0;
    end else begin
      valid <= (cnt == CW'(1));
      if (cnt != '0) begin
        // The sign bit of b carries weight -2^(W-1), so the last step subtracts.
        if (mplier[0])
          prod <= (cnt == CW'(1)) ? prod - mcand : prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/cmplx_mac_seq.sv
// Sequential complex multiply-accumulate over one shared shift-add multiplier.
// Define CMAC_SAT_EN to saturate overflowing accumulate steps instead of wrapping.
module cmplx_mac_seq
  import cmac_pkg::*;
#(
  parameter  int W     = 4,
  parameter  int GUARD = 4,
  localparam int ACC_W = acc_w(W, GUARD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             acc_en,
  input  logic             clr,
  input  logic [W-1:0]     a_re,
  input  logic [W-1:0]     a_im,
  input  logic [W-1:0]     b_re,
  input  logic [W-1:0]     b_im,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] out_re,
  output logic [ACC_W-1:0] out_im,
  output logic             ovf
);

  state_t             state;
  logic [1:0]         k, kn;
  logic [W-1:0]       ra_re, ra_im, rb_re, rb_im;
  logic [ACC_W-1:0]   acc_re, acc_im;
  logic               wovf;

  logic [W-1:0]       mult_a, mult_b;
  logic               mult_load, mult_valid;
  logic [2*W-1:0]     prod;

  logic [ACC_W:0]     prod_x, sel_x, sum;
  logic               step_ovf;
  logic [ACC_W-1:0]   step_val;
  logic               to_re;

  assign kn        = k + 2'd1;
  assign mult_load = (state == S_IDLE && start) || (state == S_ACC && k != K_IR);
  assign to_re     = (k == K_RR) || (k == K_II);

  // Product 0 is loaded straight from the ports in the same cycle start is accepted.
  always_comb begin
    mult_a = a_re;
    mult_b = b_re;
    if (state != S_IDLE) begin
      unique case (kn)
        K_II:    begin mult_a = ra_im; mult_b = rb_im; end
        K_RI:    begin mult_a = ra_re; mult_b = rb_im; end
        K_IR:    begin mult_a = ra_im; mult_b = rb_re; end
        default: begin mult_a = ra_re; mult_b = rb_re; end
      endcase
    end
  end

  seq_mult_signed #(.W(W)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .load  (mult_load),
    .a     (mult_a),
    .b     (mult_b),
    .valid (mult_valid),
    .prod  (prod)
  );

  // One extra bit of headroom exposes signed overflow of the ACC_W-bit result.
  always_comb begin
    prod_x   = {{(ACC_W+1-2*W){prod[2*W-1]}}, prod};
    sel_x    = to_re ? {acc_re[ACC_W-1], acc_re} : {acc_im[ACC_W-1], acc_im};
    sum      = (k == K_II) ? sel_x - prod_x : sel_x + prod_x;
    step_ovf = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef CMAC_SAT_EN
    if (step_ovf)
      step_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      step_val = sum[ACC_W-1:0];
`else
    step_val = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      out_re <= '0;
      out_im <= '0;
      ovf    <= 1'b0;
      k      <= K_RR;
      acc_re <= '0;
      acc_im <= '0;
      wovf   <= 1'b0;
      ra_re  <= '0;
      ra_im  <= '0;
      rb_re  <= '0;
      rb_im  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (clr) begin
            out_re <= '0;
            out_im <= '0;
            ovf    <= 1'b0;
          end
          if (start) begin
            ra_re  <= a_re;
            ra_im  <= a_im;
            rb_re  <= b_re;
            rb_im  <= b_im;
            k      <= K_RR;
            wovf   <= 1'b0;
            acc_re <= (acc_en && !clr) ? out_re : '0;
            acc_im <= (acc_en && !clr) ? out_im : '0;
            busy   <= 1'b1;
            state  <= S_MUL;
          end
        end
        S_MUL: if (mult_valid) state <= S_ACC;
        S_ACC: begin
          if (to_re) acc_re <= step_val;
          else       acc_im <= step_val;
          wovf <= wovf | step_ovf;
          if (k == K_IR) state <= S_DONE;
          else begin
            k     <= kn;
            state <= S_MUL;
          end
        end
        S_DONE: begin
          out_re <= acc_re;
          out_im <= acc_im;
          ovf    <= ovf | wovf;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmplx_mac_seq.sv
// Scoreboard bench for cmplx_mac_seq (GUARD=0 so overflow is reachable); the reference
// model works on plain integers, one signed add/subtract per product.
module tb_cmplx_mac_seq;

  localparam int W     = 4;
  localparam int GUARD = 0;
  localparam int ACC_W = 2 * W + 1 + GUARD;
  localparam int LAT   = 4 * (W + 1) + 1;

  logic             clk = 1'b0;
  logic             rst, start, acc_en, clr;
  logic [W-1:0]     a_re, a_im, b_re, b_im;
  logic             busy, done, ovf;
  logic [ACC_W-1:0] out_re, out_im;

  cmplx_mac_seq #(.W(W), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_en(acc_en), .clr(clr),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .busy(busy), .done(done), .out_re(out_re), .out_im(out_im), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {int re; int im; bit ovf; int t0;} exp_t;
  exp_t q[$];
  exp_t mon_e;

  int checks = 0, failures = 0, cyc = 0, busy_cnt = 0;
  int m_re = 0, m_im = 0;
  bit m_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One accumulate step: detect out-of-range, then wrap or clamp.
  task automatic acc_step(inout int v, inout bit o);
    int hi, lo;
    hi = (1 << (ACC_W - 1)) - 1;
    lo = -(1 << (ACC_W - 1));
    if (v > hi || v < lo) begin
      o = 1'b1;
`ifdef CMAC_SAT_EN
      v = (v > hi) ? hi : lo;
`else
      v = v & ((1 << ACC_W) - 1);
      if (v > hi) v -= (1 << ACC_W);
`endif
    end
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_out_re"}, int'($signed(out_re)), m_re);
    chk({tag, "_out_im"}, int'($signed(out_im)), m_im);
    chk({tag, "_ovf"}, int'(ovf), int'(m_ovf));
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  task automatic run_op(input int ar, input int ai, input int br, input int bi,
                        input bit ae, input bit cl, input bit disturb);
    exp_t e;
    int re, im;
    bit o, got;
    if (cl) begin m_re = 0; m_im = 0; m_ovf = 1'b0; end
    re = ae ? m_re : 0;
    im = ae ? m_im : 0;
    o  = 1'b0;
    re += ar * br; acc_step(re, o);
    re -= ai * bi; acc_step(re, o);
    im += ar * bi; acc_step(im, o);
    im += ai * br; acc_step(im, o);
    m_re = re; m_im = im; m_ovf = m_ovf | o;

    a_re = ar[W-1:0]; a_im = ai[W-1:0]; b_re = br[W-1:0]; b_im = bi[W-1:0];
    acc_en = ae; clr = cl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr = 1'b0;
    e.re = m_re; e.im = m_im; e.ovf = m_ovf; e.t0 = cyc;
    q.push_back(e);

    if (disturb) begin
      repeat (4) @(posedge clk);
      #1;
      a_re = 4'd7; a_im = 4'd5; b_re = 4'd3; b_im = 4'd6; acc_en = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
    end

    got = 1'b0;
    for (int i = 0; i < LAT + 10 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL done_timeout no done within %0d cycles", LAT + 10);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    m_re = 0; m_im = 0; m_ovf = 1'b0;
    @(negedge clk);
    check_idle_state("clr");
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          mon_e = q.pop_front();
          chk("out_re", int'($signed(out_re)), mon_e.re);
          chk("out_im", int'($signed(out_im)), mon_e.im);
          chk("ovf", int'(ovf), int'(mon_e.ovf));
          chk("latency", cyc - mon_e.t0, LAT);
          chk("busy_cycles", busy_cnt, LAT);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; acc_en = 1'b0; clr = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_state("reset");
    @(posedge clk); #1;

    run_op(2, 3, 2, 1, 1'b0, 1'b0, 1'b0);
    run_op(2, 2, 1, 2, 1'b0, 1'b0, 1'b0);
    run_op(1, 0, 1, 3, 1'b1, 1'b0, 1'b0);
    run_op(-8, -8, -8, -8, 1'b0, 1'b0, 1'b0);
    run_op(-8, -8, -8, -8, 1'b1, 1'b0, 1'b0);
    run_op(-8, -8, -8, -8, 1'b1, 1'b0, 1'b0);
    do_clr();
    run_op(2, 3, 2, 1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of an operation: no done, outputs zeroed.
    a_re = 4'd2; a_im = 4'd3; b_re = 4'd2; b_im = 4'd1; acc_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_re = 0; m_im = 0; m_ovf = 1'b0;
    @(negedge clk);
    check_idle_state("midop_reset");
    repeat (LAT + 5) @(posedge clk);
    #1;
    run_op(2, 3, 2, 1, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
             int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
             1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
